// File: rtl/enemy_bullet_hit_scheduler.sv
// enemy_bullet_hit_scheduler
//
// Once per frame, walks the enemy bullet slots with a single shared
// rectangle-overlap comparator (one slot per clock). Owns player health:
// collects the colliding slots into a pending mask, emits them as a one-cycle
// kill strobe, takes at most one point of health per frame and latches boom
// once health reaches zero.
//
// Optional feature: define HIT_SCHED_INVULN_EN to add a post-hit immunity
// window of INVULN_FRAMES accepted frames plus an 'invuln' output.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   frame_tick     one-cycle pulse, starts a scan when idle
//   p_x, p_y       player position, snapshotted when a scan starts
//   player_en      player present; 0 suppresses all collisions
//   eb_x_bus       packed bullet x, slot i at [10i+9:10i]
//   eb_y_bus       packed bullet y, same packing
//   eb_valid       per-slot bullet alive
//   kill_mask      one-cycle strobe of bullets to clear
//   hit            one-cycle pulse, health was decremented
//   health         current player health
//   boom           sticky, player destroyed
//   busy           scan in progress
//   overrun        sticky, frame_tick arrived while busy
//   invuln         (HIT_SCHED_INVULN_EN only) immunity window active
//
// Frame handshake: frame_tick is accepted only in IDLE with boom low; busy
// rises the next cycle and stays high for NUM_SLOTS+1 cycles. The bullet
// buses and eb_valid must be held stable while busy. A tick seen while busy
// is dropped and recorded in overrun.

module enemy_bullet_hit_scheduler #(
  parameter int NUM_SLOTS     = 8,
  parameter int INIT_HEALTH   = 3,
  parameter int INVULN_FRAMES = 30
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_tick,
  input  logic [9:0]              p_x,
  input  logic [9:0]              p_y,
  input  logic                    player_en,
  input  logic [10*NUM_SLOTS-1:0] eb_x_bus,
  input  logic [10*NUM_SLOTS-1:0] eb_y_bus,
  input  logic [NUM_SLOTS-1:0]    eb_valid,
  output logic [NUM_SLOTS-1:0]    kill_mask,
  output logic                    hit,
  output logic [3:0]              health,
  output logic                    boom,
  output logic                    busy,
  output logic                    overrun
`ifdef HIT_SCHED_INVULN_EN
  ,
  output logic                    invuln
`endif
);

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

  // Parameter range guard, evaluated at elaboration only.
  if (NUM_SLOTS < 2 || NUM_SLOTS > 16 || INIT_HEALTH < 1 || INIT_HEALTH > 15 ||
      INVULN_FRAMES < 0 || INVULN_FRAMES > 63) begin : g_param_check
    $error("enemy_bullet_hit_scheduler: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [NUM_SLOTS-1:0] pending;
  logic [9:0]           snap_x;
  logic [9:0]           snap_y;

  // Currently addressed slot.
  logic [9:0]           ex;
  logic [9:0]           ey;
  logic                 ev;
  logic                 coll;
  logic [NUM_SLOTS-1:0] slot_bit;
  logic [NUM_SLOTS-1:0] pending_next;
  logic                 invuln_active;

  // Overlap sums are formed at 11 bits so coordinates near 1023 cannot wrap.
  logic [10:0] sx_ext, sy_ext, ex_ext, ey_ext;
  logic [10:0] sx_p10, sy_p50, ex_p50, ey_p40;

  always_comb begin
    ex = '0;
    ey = '0;
    ev = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (idx == IDX_W'(i)) begin
        ex = eb_x_bus[i*10 +: 10];
        ey = eb_y_bus[i*10 +: 10];
        ev = eb_valid[i];
      end
    end
  end

  assign sx_ext = {1'b0, snap_x};
  assign sy_ext = {1'b0, snap_y};
  assign ex_ext = {1'b0, ex};
  assign ey_ext = {1'b0, ey};
  assign sx_p10 = sx_ext + 11'd10;
  assign sy_p50 = sy_ext + 11'd50;
  assign ex_p50 = ex_ext + 11'd50;
  assign ey_p40 = ey_ext + 11'd40;

  assign coll = ev && player_en &&
                (sx_p10 >= ex_ext) && (sx_ext < ex_p50) &&
                (sy_p50 >= ey_ext) && (sy_ext < ey_p40);

  always_comb begin
    slot_bit = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_bit[i] = coll && (idx == IDX_W'(i));
    end
  end

  // Includes the slot being examined this cycle, so the final slot's result
  // feeds straight into the commit decision.
  assign pending_next = pending | slot_bit;

`ifdef HIT_SCHED_INVULN_EN
  logic [5:0] inv_cnt;
  assign invuln_active = (inv_cnt != 6'd0);
  assign invuln        = invuln_active;
`else
  assign invuln_active = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      pending   <= '0;
      snap_x    <= '0;
      snap_y    <= '0;
      kill_mask <= '0;
      hit       <= 1'b0;
      health    <= 4'(INIT_HEALTH);
      boom      <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
`ifdef HIT_SCHED_INVULN_EN
      inv_cnt   <= 6'd0;
`endif
    end else begin
      // Strobes default low; set only on the edge entering COMMIT.
      kill_mask <= '0;
      hit       <= 1'b0;

      // Registered one cycle behind health reaching zero.
      if (health == 4'd0) begin
        boom <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (frame_tick && !boom) begin
            snap_x  <= p_x;
            snap_y  <= p_y;
            pending <= '0;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= SCAN;
`ifdef HIT_SCHED_INVULN_EN
            if (inv_cnt != 6'd0) begin
              inv_cnt <= inv_cnt - 6'd1;
            end
`endif
          end
        end

        SCAN: begin
          if (frame_tick) begin
            overrun <= 1'b1;
          end
          pending <= pending_next;
          if (idx == LAST_IDX) begin
            // kill_mask and hit become visible during the COMMIT cycle.
            state     <= COMMIT;
            kill_mask <= pending_next;
            if ((pending_next != '0) && (health != 4'd0) && !invuln_active) begin
              health <= health - 4'd1;
              hit    <= 1'b1;
`ifdef HIT_SCHED_INVULN_EN
              inv_cnt <= 6'(INVULN_FRAMES);
`endif
            end
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end

        COMMIT: begin
          // A tick here is an overrun; the FSM always returns to IDLE first.
          if (frame_tick) begin
            overrun <= 1'b1;
          end
          idx   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          idx   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enemy_bullet_hit_scheduler.sv
// Testbench for enemy_bullet_hit_scheduler: directed vector table, hand-written
// overrun / mid-scan reset sequences, and randomized frames against a
// behavioural model of health, boom, overrun and immunity.

module tb_enemy_bullet_hit_scheduler;

  localparam int NS         = 8;
  localparam int INIT_H     = 3;
  localparam int INV_FRAMES = 30;

  logic              clk        = 1'b0;
  logic              rst_n      = 1'b0;
  logic              frame_tick = 1'b0;
  logic [9:0]        p_x        = '0;
  logic [9:0]        p_y        = '0;
  logic              player_en  = 1'b1;
  logic [10*NS-1:0]  eb_x_bus   = '0;
  logic [10*NS-1:0]  eb_y_bus   = '0;
  logic [NS-1:0]     eb_valid   = '0;
  logic [NS-1:0]     kill_mask;
  logic              hit;
  logic [3:0]        health;
  logic              boom;
  logic              busy;
  logic              overrun;
`ifdef HIT_SCHED_INVULN_EN
  logic              invuln;
`endif

  enemy_bullet_hit_scheduler #(
    .NUM_SLOTS    (NS),
    .INIT_HEALTH  (INIT_H),
    .INVULN_FRAMES(INV_FRAMES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_tick(frame_tick),
    .p_x       (p_x),
    .p_y       (p_y),
    .player_en (player_en),
    .eb_x_bus  (eb_x_bus),
    .eb_y_bus  (eb_y_bus),
    .eb_valid  (eb_valid),
    .kill_mask (kill_mask),
    .hit       (hit),
    .health    (health),
    .boom      (boom),
    .busy      (busy),
    .overrun   (overrun)
`ifdef HIT_SCHED_INVULN_EN
    ,
    .invuln    (invuln)
`endif
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;
  logic [NS-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_health;
  bit m_boom;
  bit m_overrun;
  int m_inv;

  function automatic bit collide(int sx, int sy, int ex, int ey);
    return (sx + 10 >= ex) && (sx < ex + 50) && (sy + 50 >= ey) && (sy < ey + 40);
  endfunction

  function automatic logic [NS-1:0] model_mask();
    logic [NS-1:0] m;
    m = '0;
    for (int i = 0; i < NS; i++) begin
      if (eb_valid[i] && player_en &&
          collide(int'(p_x), int'(p_y), int'(eb_x_bus[i*10 +: 10]), int'(eb_y_bus[i*10 +: 10])))
        m[i] = 1'b1;
    end
    return m;
  endfunction

  task automatic model_reset();
    m_health  = INIT_H;
    m_boom    = 1'b0;
    m_overrun = 1'b0;
    m_inv     = 0;
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit            rst;
    bit            pen;
    int            px, py;
    int            sa, ax, ay;
    int            sb, bx, by;
    logic [NS-1:0] valid;
    logic [NS-1:0] geo_kill;   // hand-derived collision mask
  } vec_t;

  task automatic drive_vec(input vec_t v);
    for (int i = 0; i < NS; i++) begin
      eb_x_bus[i*10 +: 10] = 10'd900;
      eb_y_bus[i*10 +: 10] = 10'd900;
    end
    if (v.sa >= 0) begin
      eb_x_bus[v.sa*10 +: 10] = 10'(v.ax);
      eb_y_bus[v.sa*10 +: 10] = 10'(v.ay);
    end
    if (v.sb >= 0) begin
      eb_x_bus[v.sb*10 +: 10] = 10'(v.bx);
      eb_y_bus[v.sb*10 +: 10] = 10'(v.by);
    end
    p_x       = 10'(v.px);
    p_y       = 10'(v.py);
    player_en = v.pen;
    eb_valid  = v.valid;
  endtask

  function automatic int clamp10(int v);
    if (v < 0) return 0;
    if (v > 1023) return 1023;
    return v;
  endfunction

  task automatic drive_random();
    int px, py;
    px = $urandom_range(0, 1023);
    py = $urandom_range(0, 1023);
    p_x = 10'(px);
    p_y = 10'(py);
    for (int i = 0; i < NS; i++) begin
      eb_x_bus[i*10 +: 10] = 10'(clamp10(px + $urandom_range(0, 100) - 60));
      eb_y_bus[i*10 +: 10] = 10'(clamp10(py + $urandom_range(0, 100) - 55));
    end
    eb_valid  = NS'($urandom);
    player_en = ($urandom_range(0, 7) != 0);
  endtask

  // One frame: pulse frame_tick, watch busy, capture the strobe cycle and
  // compare against the model. extra_at>0 re-pulses frame_tick in that busy cycle.
  task automatic run_frame(input string name, input logic [NS-1:0] tbl_kill,
                           input bit from_tbl, input int extra_at);
    bit            accepted;
    bit            exp_hit;
    bit            boom_before;
    bit            stray;
    logic [NS-1:0] exp_kill;
    logic [NS-1:0] kill_at;
    logic          hit_at;
    logic          boom_at;
    int            busy_cycles;

    accepted    = !m_boom;
    boom_before = m_boom;
    exp_kill    = '0;
    exp_hit     = 1'b0;
    if (accepted) begin
      exp_kill = from_tbl ? tbl_kill : model_mask();
      if (m_inv > 0) m_inv--;
      exp_hit = (exp_kill != '0) && (m_health > 0) && (m_inv == 0);
      if (exp_hit) begin
        m_health--;
`ifdef HIT_SCHED_INVULN_EN
        m_inv = INV_FRAMES;
`endif
      end
      if (extra_at >= 1 && extra_at <= NS + 1) m_overrun = 1'b1;
    end
    exp_q.push_back(exp_kill);

    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick  = 1'b0;
    busy_cycles = 0;
    stray       = 1'b0;
    kill_at     = '0;
    hit_at      = 1'b0;
    boom_at     = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (!busy) break;
      busy_cycles++;
      if (k == NS + 1) begin
        kill_at = kill_mask;
        hit_at  = hit;
        boom_at = boom;
      end else if (kill_mask != '0 || hit) begin
        stray = 1'b1;
      end
      frame_tick = (k == extra_at);
      @(negedge clk);
    end
    frame_tick = 1'b0;
    if (kill_mask != '0 || hit) stray = 1'b1;
    if (m_health == 0) m_boom = 1'b1;

    check({name, ".busy_cycles"}, busy_cycles, accepted ? NS + 1 : 0);
    check({name, ".kill_mask"}, kill_at, exp_q.pop_front());
    check({name, ".hit"}, hit_at, exp_hit);
    check({name, ".stray_strobe"}, stray, 1'b0);
    check({name, ".health"}, health, m_health);
    if (accepted) check({name, ".boom_at_commit"}, boom_at, boom_before);
    check({name, ".boom"}, boom, m_boom);
    check({name, ".overrun"}, overrun, m_overrun);
`ifdef HIT_SCHED_INVULN_EN
    check({name, ".invuln"}, invuln, m_inv != 0);
`endif
  endtask

  // ---------------- test ----------------
  vec_t vecs[10];

  initial begin
    logic activity;

    vecs[0] = '{1, 1, 100, 200,  2,  95, 180, -1,   0,   0, 8'h04, 8'h04};
    vecs[1] = '{0, 1, 100, 200,  0, 100, 200,  5,  60, 170, 8'h21, 8'h21};
    vecs[2] = '{0, 1, 100, 200,  3,  50, 200,  4, 100, 200, 8'h08, 8'h00};
    vecs[3] = '{0, 1, 100, 200,  1, 110, 200,  4, 111, 200, 8'h12, 8'h02};
    vecs[4] = '{0, 1, 100, 200,  1, 110, 200, -1,   0,   0, 8'h02, 8'h02};
    vecs[5] = '{1, 1,   0,   0,  6,   5,   5, -1,   0,   0, 8'h40, 8'h40};
    vecs[6] = '{0, 1, 100, 200,  7, 100, 250,  2, 100, 160, 8'h84, 8'h80};
    vecs[7] = '{0, 0, 100, 200,  3, 100, 200, -1,   0,   0, 8'h08, 8'h00};
    vecs[8] = '{0, 1, 1023, 1023, 0, 1023, 1023, -1,  0,   0, 8'h01, 8'h01};
    vecs[9] = '{1, 1, 500, 500,  4, 460, 480, -1,   0,   0, 8'h10, 8'h10};

    // Reset state
    do_reset();
    check("reset.health", health, INIT_H);
    check("reset.boom", boom, 1'b0);
    check("reset.busy", busy, 1'b0);
    check("reset.kill_mask", kill_mask, '0);
    check("reset.hit", hit, 1'b0);
    check("reset.overrun", overrun, 1'b0);
`ifdef HIT_SCHED_INVULN_EN
    check("reset.invuln", invuln, 1'b0);
`endif

    // Directed table: single hit, double hit, boundaries, death and stop
    for (int v = 0; v < 10; v++) begin
      if (vecs[v].rst) do_reset();
      drive_vec(vecs[v]);
      run_frame($sformatf("vec%0d", v), vecs[v].geo_kill, 1'b1, 0);
    end

    // Overrun during SCAN: scan still completes normally
    do_reset();
    drive_vec(vecs[0]);
    run_frame("ovr_scan", vecs[0].geo_kill, 1'b1, 3);

    // Overrun on the COMMIT cycle: no restart from COMMIT
    do_reset();
    drive_vec(vecs[0]);
    run_frame("ovr_commit", vecs[0].geo_kill, 1'b1, NS + 1);

    // Reset in the middle of a scan: no strobe, health restored, overrun cleared
    drive_vec(vecs[1]);
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("midrst.busy_in_reset", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    activity = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (busy || kill_mask != '0 || hit) activity = 1'b1;
      @(negedge clk);
    end
    check("midrst.no_activity", activity, 1'b0);
    check("midrst.health", health, INIT_H);
    check("midrst.overrun", overrun, 1'b0);

`ifdef HIT_SCHED_INVULN_EN
    // Back-to-back hit frames: second is absorbed by immunity
    do_reset();
    drive_vec(vecs[0]);
    run_frame("inv_first", vecs[0].geo_kill, 1'b1, 0);
    run_frame("inv_second", vecs[0].geo_kill, 1'b1, 0);
`endif

    // Randomized frames against the model
    do_reset();
    for (int n = 0; n < 40; n++) begin
      int extra;
      if (m_boom) do_reset();
      drive_random();
      extra = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, NS + 1)) : 0;
      run_frame($sformatf("rnd%0d", n), '0, 1'b0, extra);
    end

    check("scoreboard.empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
